// File: rtl/xadc_drp_arbiter_pkg.sv
// Shared definitions for the XADC DRP arbiter: DRP register addresses,
// FSM state encoding and index-width helper.
package xadc_drp_arbiter_pkg;

   localparam logic [6:0] XADC_ADDR_TEMP = 7'h00;
   localparam logic [6:0] XADC_ADDR_VPVN = 7'h03;
   localparam logic [6:0] XADC_ADDR_CFG0 = 7'h40;
   localparam logic [6:0] XADC_ADDR_CFG1 = 7'h41;
   localparam logic [6:0] XADC_ADDR_CFG2 = 7'h42;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/xadc_drp_arbiter_if.sv
// Requester-side and DRP-side signal bundle of the arbiter, plus an FSM debug tap.
// Handshake: a requester raises req with stable we/addr/di and holds it until it
// sees its one-cycle ack (err qualifies a timeout); req still high after that
// cycle counts as a fresh request.
interface xadc_drp_arbiter_if
   import xadc_drp_arbiter_pkg::*;
#(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    req_we;
   logic [7*N_REQ-1:0]  req_addr;
   logic [16*N_REQ-1:0] req_di;
   logic [N_REQ-1:0]    ack;
   logic [N_REQ-1:0]    err;
   logic [15:0]         rdata;
   logic                busy;
   logic                drp_den;
   logic                drp_dwe;
   logic [6:0]          drp_daddr;
   logic [15:0]         drp_di;
   logic [15:0]         drp_do;
   logic                drp_drdy;
   state_e              dbg_state;

   modport slave (
      input  req, req_we, req_addr, req_di, drp_do, drp_drdy,
      output ack, err, rdata, busy, drp_den, drp_dwe, drp_daddr, drp_di, dbg_state
   );

   modport master (
      output req, req_we, req_addr, req_di, drp_do, drp_drdy,
      input  ack, err, rdata, busy, drp_den, drp_dwe, drp_daddr, drp_di, dbg_state
   );
endinterface

// File: rtl/xadc_drp_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first request at or after ptr wins,
// wrapping from N_REQ-1 back to 0.
module xadc_drp_arbiter_rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = ptr;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
         cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      end
   end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Shares one XADC DRP port among N_REQ requesters: round-robin grant, one
// transaction in flight, DRDY timeout with per-requester ack/err pulses.
module xadc_drp_arbiter
   import xadc_drp_arbiter_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   xadc_drp_arbiter_if.slave bus
);

   localparam int         IW        = idx_w(N_REQ);
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_e           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    win_q, win_d;
   logic [N_REQ-1:0] win_oh_q, win_oh_d;
   logic             we_q, we_d;
   logic [6:0]       addr_q, addr_d;
   logic [15:0]      di_q, di_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [N_REQ-1:0] err_q, err_d;
   logic [15:0]      rdata_q, rdata_d;
   logic             busy_q, busy_d;
   logic             den_q, den_d;
   logic             dwe_q, dwe_d;

   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    grant_idx;

   xadc_drp_arbiter_rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr (
      .req       (bus.req),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      win_oh_d = win_oh_q;
      we_d     = we_q;
      addr_d   = addr_q;
      di_d     = di_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      ack_d    = '0;
      err_d    = '0;
      den_d    = 1'b0;
      dwe_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               win_d    = grant_idx;
               win_oh_d = grant;
               for (int i = 0; i < N_REQ; i++) begin
                  if (grant[i]) begin
                     we_d   = bus.req_we[i];
                     addr_d = bus.req_addr[i*7 +: 7];
                     di_d   = bus.req_di[i*16 +: 16];
                  end
               end
               den_d   = 1'b1;
               dwe_d   = we_d;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // DRDY is checked before the timeout so a reply on the last cycle still counts.
            if (bus.drp_drdy) begin
               if (!we_q) rdata_d = bus.drp_do;
               ack_d   = win_oh_q;
               state_d = ST_GAP;
            end else if (cnt_q == TIMEOUT_C) begin
               rdata_d = '0;
               ack_d   = win_oh_q;
               err_d   = win_oh_q;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_GAP: begin
            ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         win_q    <= '0;
         win_oh_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         di_q     <= '0;
         cnt_q    <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         den_q    <= 1'b0;
         dwe_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         win_oh_q <= win_oh_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         di_q     <= di_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         den_q    <= den_d;
         dwe_q    <= dwe_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = busy_q;
   assign bus.drp_den   = den_q;
   assign bus.drp_dwe   = dwe_q;
   assign bus.drp_daddr = addr_q;
   assign bus.drp_di    = di_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Bench for xadc_drp_arbiter: an XADC DRP reply model plus a scoreboard of
// expected {requester, err, rdata} completions, one task per scenario.
module tb_xadc_drp_arbiter;
   import xadc_drp_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int TO = 10;
   localparam int W  = 25;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   xadc_drp_arbiter_if #(.N_REQ(N)) bus ();

   xadc_drp_arbiter #(
      .N_REQ   (N),
      .TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [15:0]  last_rd = 16'h0000;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // XADC reply model
   bit          model_en    = 1'b0;
   bit          use_addr    = 1'b0;
   bit          force_drdy  = 1'b0;
   int          model_delay = 3;
   logic [15:0] model_do    = 16'h0000;
   int          den_cnt = 0, dwe_cnt = 0, overlap = 0, den_cyc = 0;
   logic [6:0]  den_addr;
   logic [15:0] den_di;
   logic        den_we;
   bit          armed = 1'b0;
   int          cd = 0;

   initial begin
      bus.drp_drdy = 1'b0;
      bus.drp_do   = 16'h0000;
      forever begin
         @(posedge clk);
         #2;
         bus.drp_drdy = 1'b0;
         if (bus.drp_dwe) dwe_cnt++;
         if (bus.drp_den) begin
            den_cnt++;
            if (armed) overlap++;
            den_cyc  = cyc;
            den_addr = bus.drp_daddr;
            den_we   = bus.drp_dwe;
            den_di   = bus.drp_di;
            if (model_en) begin
               cd    = model_delay;
               armed = 1'b1;
            end
         end else if (armed) begin
            cd--;
            if (cd == 0) begin
               bus.drp_drdy = 1'b1;
               bus.drp_do   = use_addr ? (16'h5A00 ^ {9'h000, den_addr}) : model_do;
               armed        = 1'b0;
            end
         end
         if (force_drdy) begin
            bus.drp_drdy = 1'b1;
            bus.drp_do   = 16'hDEAD;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [W-1:0] pack_exp(input int idx, input bit e, input logic [15:0] rd);
      return {8'(idx), e, rd};
   endfunction

   task automatic set_req(input int i, input bit we, input logic [6:0] a, input logic [15:0] d);
      bus.req[i]             = 1'b1;
      bus.req_we[i]          = we;
      bus.req_addr[i*7 +: 7] = a;
      bus.req_di[i*16 +: 16] = d;
   endtask

   task automatic wait_ack(input int budget, output bit got, output int idx, output bit e,
                           output logic [15:0] rd, output int lat);
      got = 1'b0; idx = -1; e = 1'b0; rd = '0; lat = 0;
      for (int c = 0; c < budget && !got; c++) begin
         @(posedge clk);
         #1;
         if (bus.ack != '0) begin
            got = 1'b1;
            for (int i = 0; i < N; i++) if (bus.ack[i]) idx = i;
            e   = |bus.err;
            rd  = bus.rdata;
            lat = cyc - den_cyc;
         end
      end
   endtask

   task automatic wait_den(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         #1;
         if (bus.drp_den) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_di = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.ack, bus.err, bus.rdata, bus.busy, bus.drp_den, bus.drp_dwe, bus.drp_daddr, bus.drp_di} !== '0) begin
         errors++;
         $display("FAIL reset_outputs ack=%b err=%b rdata=%h busy=%b den=%b dwe=%b daddr=%h di=%h required all zero",
                  bus.ack, bus.err, bus.rdata, bus.busy, bus.drp_den, bus.drp_dwe, bus.drp_daddr, bus.drp_di);
      end
      checks++;
      if (bus.dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state got=%0d required=%0d", bus.dbg_state, ST_IDLE);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      bit got, e; int idx, lat, d0, w0; logic [15:0] rd; logic [W-1:0] ex;
      model_en = 1'b1; use_addr = 1'b0; model_do = 16'hABC0; model_delay = 3;
      d0 = den_cnt; w0 = dwe_cnt;
      set_req(0, 1'b0, XADC_ADDR_VPVN, 16'h0000);
      exp_q.push_back(pack_exp(0, 1'b0, 16'hABC0));
      last_rd = 16'hABC0;
      wait_ack(40, got, idx, e, rd, lat);
      bus.req[0] = 1'b0;
      ex = exp_q.pop_front();
      checks++;
      if (!got || idx != int'(ex[24:17]) || e !== ex[16] || rd !== ex[15:0]) begin
         errors++;
         $display("FAIL read_sb got=%0b idx=%0d err=%0b rdata=%h required idx=%0d err=%0b rdata=%h",
                  got, idx, e, rd, ex[24:17], ex[16], ex[15:0]);
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL read_latency got=%0d required=4", lat);
      end
      checks++;
      if (den_cnt - d0 != 1 || dwe_cnt - w0 != 0 || den_addr !== XADC_ADDR_VPVN) begin
         errors++;
         $display("FAIL read_drp den_pulses=%0d dwe_cycles=%0d daddr=%h required 1 0 03",
                  den_cnt - d0, dwe_cnt - w0, den_addr);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.ack !== '0 || bus.rdata !== 16'hABC0) begin
         errors++;
         $display("FAIL read_pulse_hold ack=%b rdata=%h required 000 abc0", bus.ack, bus.rdata);
      end
   endtask

   task automatic test_write();
      bit got, e; int idx, lat, w0; logic [15:0] rd; logic [W-1:0] ex;
      model_en = 1'b1; use_addr = 1'b0; model_do = 16'h7777; model_delay = 2;
      w0 = dwe_cnt;
      set_req(2, 1'b1, XADC_ADDR_CFG1, 16'h313F);
      exp_q.push_back(pack_exp(2, 1'b0, last_rd));
      repeat (2) @(posedge clk);
      #1;
      bus.req_addr[2*7 +: 7]  = 7'h7F;
      bus.req_di[2*16 +: 16]  = 16'hFFFF;
      bus.req_we[2]           = 1'b0;
      wait_ack(40, got, idx, e, rd, lat);
      bus.req[2] = 1'b0;
      ex = exp_q.pop_front();
      checks++;
      if (!got || idx != int'(ex[24:17]) || e !== ex[16] || rd !== ex[15:0]) begin
         errors++;
         $display("FAIL write_sb got=%0b idx=%0d err=%0b rdata=%h required idx=%0d err=%0b rdata=%h",
                  got, idx, e, rd, ex[24:17], ex[16], ex[15:0]);
      end
      checks++;
      if (den_we !== 1'b1 || den_addr !== XADC_ADDR_CFG1 || den_di !== 16'h313F || dwe_cnt - w0 != 1) begin
         errors++;
         $display("FAIL write_drp dwe=%b daddr=%h di=%h dwe_cycles=%0d required 1 41 313f 1",
                  den_we, den_addr, den_di, dwe_cnt - w0);
      end
      checks++;
      if (bus.drp_daddr !== XADC_ADDR_CFG1 || bus.drp_di !== 16'h313F) begin
         errors++;
         $display("FAIL write_latched daddr=%h di=%h required 41 313f", bus.drp_daddr, bus.drp_di);
      end
   endtask

   task automatic test_contention();
      bit got, e; int idx, lat; logic [15:0] rd; logic [W-1:0] ex;
      logic [6:0] a[3];
      a[0] = XADC_ADDR_TEMP; a[1] = XADC_ADDR_VPVN; a[2] = XADC_ADDR_CFG0;
      model_en = 1'b1; use_addr = 1'b1; model_delay = 2;
      overlap = 0;
      for (int i = 0; i < 3; i++) begin
         set_req(i, 1'b0, a[i], 16'h0000);
         exp_q.push_back(pack_exp(i, 1'b0, 16'h5A00 ^ {9'h000, a[i]}));
      end
      for (int k = 0; k < 9; k++) begin
         wait_ack(40, got, idx, e, rd, lat);
         if (k < 3 && idx >= 0) bus.req[idx] = 1'b0;
         if (k == 2) begin
            for (int i = 0; i < 6; i++) begin
               set_req(i % 3, 1'b0, a[i % 3], 16'h0000);
               exp_q.push_back(pack_exp(i % 3, 1'b0, 16'h5A00 ^ {9'h000, a[i % 3]}));
            end
         end
         if (k == 8) bus.req = '0;
         ex = exp_q.pop_front();
         checks++;
         if (!got || idx != int'(ex[24:17]) || e !== ex[16] || rd !== ex[15:0]) begin
            errors++;
            $display("FAIL contention_sb%0d got=%0b idx=%0d err=%0b rdata=%h required idx=%0d err=%0b rdata=%h",
                     k, got, idx, e, rd, ex[24:17], ex[16], ex[15:0]);
         end
      end
      last_rd = 16'h5A00 ^ {9'h000, a[2]};
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL contention_overlap got=%0d required=0", overlap);
      end
   endtask

   task automatic test_timeout();
      bit got, e, seen; int idx, lat; logic [15:0] rd; logic [W-1:0] ex;
      model_en = 1'b0;
      set_req(1, 1'b0, XADC_ADDR_TEMP, 16'h0000);
      exp_q.push_back(pack_exp(1, 1'b1, 16'h0000));
      wait_ack(40, got, idx, e, rd, lat);
      bus.req[1] = 1'b0;
      ex = exp_q.pop_front();
      checks++;
      if (!got || idx != int'(ex[24:17]) || e !== ex[16] || rd !== ex[15:0] || bus.err !== 3'b010) begin
         errors++;
         $display("FAIL timeout_sb got=%0b idx=%0d err=%b rdata=%h required idx=%0d err=010 rdata=%h",
                  got, idx, bus.err, rd, ex[24:17], ex[15:0]);
      end
      checks++;
      if (lat != TO + 2) begin
         errors++;
         $display("FAIL timeout_latency got=%0d required=%0d", lat, TO + 2);
      end
      // follow-up request, dropped right after its DEN
      model_en = 1'b1; use_addr = 1'b1; model_delay = 3;
      @(posedge clk);
      #1;
      set_req(0, 1'b0, XADC_ADDR_VPVN, 16'h0000);
      exp_q.push_back(pack_exp(0, 1'b0, 16'h5A03));
      wait_den(seen);
      bus.req[0] = 1'b0;
      wait_ack(40, got, idx, e, rd, lat);
      ex = exp_q.pop_front();
      checks++;
      if (!seen || !got || idx != int'(ex[24:17]) || e !== ex[16] || rd !== ex[15:0]) begin
         errors++;
         $display("FAIL after_timeout_sb den=%0b got=%0b idx=%0d err=%0b rdata=%h required idx=%0d err=%0b rdata=%h",
                  seen, got, idx, e, rd, ex[24:17], ex[16], ex[15:0]);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit got, e, seen; int idx, lat, stray; logic [15:0] rd; logic [W-1:0] ex;
      model_en = 1'b0;
      set_req(1, 1'b0, XADC_ADDR_CFG2, 16'h0000);
      wait_den(seen);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.req = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (!seen || bus.dbg_state !== ST_IDLE || bus.drp_den !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== 16'h0000) begin
         errors++;
         $display("FAIL rst_mid_wait den_seen=%0b state=%0d den=%b busy=%b rdata=%h required 1 0 0 0 0000",
                  seen, bus.dbg_state, bus.drp_den, bus.busy, bus.rdata);
      end
      stray = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         force_drdy = (c == 1);
         if (bus.ack != '0 || bus.err != '0 || bus.drp_den) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL stale_drdy stray_cycles=%0d required=0", stray);
      end
      model_en = 1'b1; use_addr = 1'b1; model_delay = 2;
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, XADC_ADDR_TEMP, 16'h0000);
      exp_q.push_back(pack_exp(0, 1'b0, 16'h5A00));
      wait_ack(40, got, idx, e, rd, lat);
      bus.req = '0;
      ex = exp_q.pop_front();
      checks++;
      if (!got || idx != int'(ex[24:17]) || e !== ex[16] || rd !== ex[15:0]) begin
         errors++;
         $display("FAIL post_reset_grant got=%0b idx=%0d err=%0b rdata=%h required idx=%0d err=%0b rdata=%h",
                  got, idx, e, rd, ex[24:17], ex[16], ex[15:0]);
      end
   endtask

   task automatic test_drdy_on_timeout();
      bit got, e; int idx, lat; logic [15:0] rd; logic [W-1:0] ex;
      model_en = 1'b1; use_addr = 1'b1; model_delay = TO + 1;
      @(posedge clk);
      #1;
      set_req(2, 1'b0, XADC_ADDR_CFG2, 16'h0000);
      exp_q.push_back(pack_exp(2, 1'b0, 16'h5A42));
      wait_ack(40, got, idx, e, rd, lat);
      bus.req[2] = 1'b0;
      ex = exp_q.pop_front();
      checks++;
      if (!got || idx != int'(ex[24:17]) || e !== ex[16] || rd !== ex[15:0]) begin
         errors++;
         $display("FAIL drdy_at_timeout_sb got=%0b idx=%0d err=%0b rdata=%h required idx=%0d err=%0b rdata=%h",
                  got, idx, e, rd, ex[24:17], ex[16], ex[15:0]);
      end
      checks++;
      if (lat != TO + 2) begin
         errors++;
         $display("FAIL drdy_at_timeout_latency got=%0d required=%0d", lat, TO + 2);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_contention();
      test_timeout();
      test_reset_mid_wait();
      test_drdy_on_timeout();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
